// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - NAND command/address sequencer driving the latch units
module cmd_sequencer #(
    parameter int T_WB       = 10,
    parameter int RB_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd1,
    input  logic [39:0] addr,
    input  logic [2:0]  addr_cnt,
    input  logic        cmd2_en,
    input  logic [7:0]  cmd2,
    input  logic        rb_wait_en,
    input  logic        nand_rb,
    input  logic        lu_busy,
    output logic        cle_act,
    output logic        ale_act,
    output logic [15:0] lu_data,
    output logic        busy,
    output logic        done,
    output logic        timeout
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CMD1     = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_CMD2     = 4'd3;
    localparam logic [3:0] S_LU_START = 4'd4;
    localparam logic [3:0] S_LU_END   = 4'd5;
    localparam logic [3:0] S_WB       = 4'd6;
    localparam logic [3:0] S_RB       = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;

    localparam logic [1:0] P_CMD1 = 2'd0;
    localparam logic [1:0] P_ADDR = 2'd1;
    localparam logic [1:0] P_CMD2 = 2'd2;

    localparam logic [16:0] L_WB_LAST = 17'(T_WB - 1);
    localparam logic [16:0] L_RB_LAST = 17'(RB_TIMEOUT - 1);

    logic [3:0]  r_state;
    logic [1:0]  r_phase;
    logic [7:0]  r_cmd1;
    logic [39:0] r_addr;
    logic [2:0]  r_addr_cnt;
    logic        r_cmd2_en;
    logic [7:0]  r_cmd2;
    logic        r_rb_wait_en;
    logic [2:0]  r_idx;
    logic [16:0] r_cnt;
    logic        r_timeout;

    logic [7:0]  w_addr_byte;
    logic [2:0]  w_idx_next;
    logic [3:0]  w_after_cmd2;
    logic [3:0]  w_after_addr;

    always_comb begin
        w_addr_byte = r_addr[7:0];
        case (r_idx)
            3'd1:    w_addr_byte = r_addr[15:8];
            3'd2:    w_addr_byte = r_addr[23:16];
            3'd3:    w_addr_byte = r_addr[31:24];
            3'd4:    w_addr_byte = r_addr[39:32];
            default: w_addr_byte = r_addr[7:0];
        endcase
    end

    assign w_idx_next   = r_idx + 3'd1;
    assign w_after_cmd2 = r_rb_wait_en ? S_WB : S_FIN;
    assign w_after_addr = r_cmd2_en ? S_CMD2 : w_after_cmd2;

    // Activates are held off while a latch unit is still busy.
    assign cle_act = ((r_state == S_CMD1) || (r_state == S_CMD2)) && !lu_busy;
    assign ale_act = (r_state == S_ADDR) && !lu_busy;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FIN);
    assign timeout = (r_state == S_FIN) && r_timeout;

    always_comb begin
        lu_data = 16'h0000;
        case (r_state)
            S_CMD1: lu_data = {8'h00, r_cmd1};
            S_ADDR: lu_data = {8'h00, w_addr_byte};
            S_CMD2: lu_data = {8'h00, r_cmd2};
            S_LU_START, S_LU_END: begin
                case (r_phase)
                    P_CMD1:  lu_data = {8'h00, r_cmd1};
                    P_ADDR:  lu_data = {8'h00, w_addr_byte};
                    default: lu_data = {8'h00, r_cmd2};
                endcase
            end
            default: lu_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= P_CMD1;
            r_cmd1       <= 8'h00;
            r_addr       <= 40'h0;
            r_addr_cnt   <= 3'd0;
            r_cmd2_en    <= 1'b0;
            r_cmd2       <= 8'h00;
            r_rb_wait_en <= 1'b0;
            r_idx        <= 3'd0;
            r_cnt        <= 17'd0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cmd1       <= cmd1;
                        r_addr       <= addr;
                        r_addr_cnt   <= (addr_cnt > 3'd5) ? 3'd5 : addr_cnt;
                        r_cmd2_en    <= cmd2_en;
                        r_cmd2       <= cmd2;
                        r_rb_wait_en <= rb_wait_en;
                        r_idx        <= 3'd0;
                        r_cnt        <= 17'd0;
                        r_timeout    <= 1'b0;
                        r_state      <= S_CMD1;
                    end
                end
                S_CMD1: if (!lu_busy) begin r_phase <= P_CMD1; r_state <= S_LU_START; end
                S_ADDR: if (!lu_busy) begin r_phase <= P_ADDR; r_state <= S_LU_START; end
                S_CMD2: if (!lu_busy) begin r_phase <= P_CMD2; r_state <= S_LU_START; end
                S_LU_START: if (lu_busy) r_state <= S_LU_END;
                S_LU_END: begin
                    if (!lu_busy) begin
                        r_cnt <= 17'd0;
                        case (r_phase)
                            P_CMD1:  r_state <= (r_addr_cnt != 3'd0) ? S_ADDR : w_after_addr;
                            P_ADDR: begin
                                r_idx   <= w_idx_next;
                                r_state <= (w_idx_next == r_addr_cnt) ? w_after_addr : S_ADDR;
                            end
                            default: r_state <= w_after_cmd2;
                        endcase
                    end
                end
                S_WB: begin
                    if (r_cnt == L_WB_LAST) begin
                        r_cnt   <= 17'd0;
                        r_state <= S_RB;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                S_RB: begin
                    if (nand_rb) begin
                        r_state <= S_FIN;
                    end else if (r_cnt == L_RB_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                S_FIN: begin
                    r_cnt     <= 17'd0;
                    r_timeout <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter T_WB, default 10, cycles waited after the last latch before R/B# is sampled (t_WB).
REQ-002 Parameter RB_TIMEOUT, default 65535, maximum cycles spent waiting for R/B# to go high.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 cmd1  in  8  first command opcode.
REQ-007 addr  in  40  address bytes; addr[7:0] is issued first.
REQ-008 addr_cnt  in  3  number of address bytes, 0..5; values 6..7 are treated as 5.
REQ-009 cmd2_en  in  1  issue a second command after the address bytes.
REQ-010 cmd2  in  8  second command opcode.
REQ-011 rb_wait_en  in  1  wait for R/B# ready after the sequence.
REQ-012 nand_rb  in  1  NAND R/B#; 1 = ready.
REQ-013 lu_busy  in  1  OR of the busy outputs of the command and address latch units.
REQ-014 cle_act  out  1  one-cycle activate to the command latch unit.
REQ-015 ale_act  out  1  one-cycle activate to the address latch unit.
REQ-016 lu_data  out  16  byte to latch, zero-extended to 16 bits.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 timeout  out  1  one-cycle pulse coincident with done when the R/B# wait expires.

Function
REQ-020 States: IDLE, CMD1, ADDR, CMD2, LU_START, LU_END, WB, RB, FIN.
REQ-021 In IDLE, start=1 captures cmd1, addr, addr_cnt (clamped), cmd2_en, cmd2 and rb_wait_en into registers, then goes to CMD1; later input changes have no effect.
REQ-022 CMD1: drive lu_data={8'h00,cmd1}, pulse cle_act for 1 cycle, then go to LU_START.
REQ-023 LU_START: hold until lu_busy=1, then go to LU_END; LU_END: hold until lu_busy=0, then advance to the next phase.
REQ-024 lu_data stays stable from the activate cycle until the cycle in which lu_busy falls.
REQ-025 Phase order: CMD1 -> ADDR x addr_cnt (skipped if 0) -> CMD2 (skipped if cmd2_en=0) -> WB (skipped if rb_wait_en=0) -> FIN.
REQ-026 ADDR: a 3-bit byte index starts at 0; lu_data={8'h00,addr[8*idx+:8]}; pulse ale_act; after LU_END, increment idx and repeat until idx=addr_cnt.
REQ-027 CMD2: identical to CMD1, but uses cmd2.
REQ-028 WB: count T_WB cycles, then go to RB.
REQ-029 RB: a 17-bit counter increments each cycle; nand_rb=1 -> FIN with timeout=0; count reaching RB_TIMEOUT with nand_rb=0 -> FIN with timeout=1.
REQ-030 FIN: done=1 (plus timeout if flagged) for exactly 1 cycle, lu_data=0, then IDLE; busy falls in the cycle after FIN.
REQ-031 cle_act and ale_act are never high together and are never asserted while lu_busy=1.
REQ-032 start while busy=1 is ignored and is not queued.
REQ-033 lu_data=0 outside the CMD1/ADDR/CMD2/LU_START/LU_END states.

Reset
REQ-034 rst=1 immediately forces IDLE and sets cle_act, ale_act, busy, done and timeout to 0, lu_data to 0, and all counters and captured registers to 0.
REQ-035 Reset during any phase aborts the sequence with no done pulse; the first start after rst falls is accepted normally.

Verification
REQ-036 start, cmd1=8'h00, addr=40'h0504030201, addr_cnt=5, cmd2_en=1, cmd2=8'h30, rb_wait_en=1, latch model busy for 4 cycles, nand_rb low for 50 cycles -> cle 00, ale 01,02,03,04,05, cle 30 in order; done after R/B# rises, timeout=0.
REQ-037 start, cmd1=8'hFF, addr_cnt=0, cmd2_en=0, rb_wait_en=0 -> exactly one cle_act pulse with lu_data=16'h00FF; done follows the fall of lu_busy, with no WB or RB wait.
REQ-038 RB_TIMEOUT=100, nand_rb held 0 -> done=1 and timeout=1 in the same cycle, 100 cycles after T_WB expires.
REQ-039 Second start pulse during the ADDR phase -> ignored; exactly one done pulse.
REQ-040 rst pulsed during the third address byte -> outputs at reset values, no done pulse; a fresh start completes correctly.
REQ-041 addr_cnt=7 -> exactly 5 ale_act pulses.
